// File: rtl/alu_seq_pkg.sv
// Shared constants, ALU opcode encodings and sequencer state type for the
// ALU op sequencer. The optional ALU_SEQ_FLAGS_EN build adds zero/carry flags.
package alu_seq_pkg;

  localparam int SEQ_DW   = 32;
  localparam int SEQ_NREG = 4;
  localparam int SEQ_RW   = $clog2(SEQ_NREG);

  localparam logic [2:0] OP_PASSA = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_INC   = 3'd5;
  localparam logic [2:0] OP_DEC   = 3'd6;
  localparam logic [2:0] OP_PASSB = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WB    = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x DW register file: two combinational read ports, one synchronous
// write port, asynchronous active-low clear to all zero.
module alu_seq_regfile #(
  parameter int DW   = 32,
  parameter int NREG = 4,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [RW-1:0] raddr_a_i,
  output logic [DW-1:0] rdata_a_o,
  input  logic [RW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] rf_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (we_i) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = rf_q[raddr_a_i];
  assign rdata_b_o = rf_q[raddr_b_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues register-file instructions to an external combinational ALU and
// writes results back. Define ALU_SEQ_FLAGS_EN to add res_zero/res_carry.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW   = SEQ_DW,
  parameter int NREG = SEQ_NREG,
  localparam int RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_load,
  input  logic [2:0]    in_opcode,
  input  logic [RW-1:0] in_dst,
  input  logic [RW-1:0] in_sa,
  input  logic [RW-1:0] in_sb,
  input  logic [DW-1:0] in_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [DW-1:0] alu_y,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
`ifdef ALU_SEQ_FLAGS_EN
  output logic          res_zero,
  output logic          res_carry,
`endif
  output logic [RW-1:0] res_dst
);

  state_e        state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]    alu_op_q, alu_op_d;
  logic [RW-1:0] dst_q, dst_d, res_dst_q, res_dst_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic          res_valid_q, res_valid_d;
  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata, rd_a, rd_b;

`ifdef ALU_SEQ_FLAGS_EN
  logic res_zero_q, res_zero_d, res_carry_q, res_carry_d;

  // Carry/borrow out of a DW+1-bit recompute of the add/sub the ALU performed.
  function automatic logic carry_of(input logic [2:0] op,
                                    input logic [DW-1:0] a,
                                    input logic [DW-1:0] b);
    logic [DW:0] s;
    s = '0;
    case (op)
      OP_ADD:  s = {1'b0, a} + {1'b0, b};
      OP_SUB:  s = {1'b0, a} - {1'b0, b};
      OP_INC:  s = {1'b0, a} + {{DW{1'b0}}, 1'b1};
      OP_DEC:  s = {1'b0, a} - {{DW{1'b0}}, 1'b1};
      default: s = '0;
    endcase
    return s[DW];
  endfunction
`endif

  alu_seq_regfile #(.DW(DW), .NREG(NREG)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (in_sa),
    .rdata_a_o (rd_a),
    .raddr_b_i (in_sb),
    .rdata_b_o (rd_b)
  );

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    dst_d       = dst_q;
    res_data_d  = res_data_q;
    res_dst_d   = res_dst_q;
    res_valid_d = res_valid_q;
    rf_we       = 1'b0;
    rf_waddr    = dst_q;
    rf_wdata    = alu_y;
`ifdef ALU_SEQ_FLAGS_EN
    res_zero_d  = res_zero_q;
    res_carry_d = res_carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_load) begin
            rf_we       = 1'b1;
            rf_waddr    = in_dst;
            rf_wdata    = in_imm;
            res_data_d  = in_imm;
            res_dst_d   = in_dst;
            res_valid_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            res_zero_d  = (in_imm == '0);
            res_carry_d = 1'b0;
`endif
            state_d     = ST_HOLD;
          end else begin
            alu_a_d  = rd_a;
            alu_b_d  = rd_b;
            alu_op_d = in_opcode;
            dst_d    = in_dst;
            state_d  = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Operands held a full cycle here so the external ALU settles.
      ST_ISSUE: state_d = ST_WB;
      ST_WB: begin
        rf_we       = 1'b1;
        res_data_d  = alu_y;
        res_dst_d   = dst_q;
        res_valid_d = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
        res_zero_d  = (alu_y == '0);
        res_carry_d = carry_of(alu_op_q, alu_a_q, alu_b_q);
`endif
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= 3'd0;
      dst_q       <= '0;
      res_data_q  <= '0;
      res_dst_q   <= '0;
      res_valid_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero_q  <= 1'b0;
      res_carry_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      dst_q       <= dst_d;
      res_data_q  <= res_data_d;
      res_dst_q   <= res_dst_d;
      res_valid_q <= res_valid_d;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero_q  <= res_zero_d;
      res_carry_q <= res_carry_d;
`endif
    end
  end

  // in_ready is forced low while reset is held.
  assign in_ready   = rst_n & (state_q == ST_IDLE);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_dst    = res_dst_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign res_zero   = res_zero_q;
  assign res_carry  = res_carry_q;
`endif

endmodule
